// File: rtl/tone_sequencer.sv
// Multi-channel timed tone sequencer: one-deep request slot per channel, fixed-priority
// launch with optional pre-emption, registered pitch output with an optional silent gap.
module tone_sequencer #(
  parameter int N_CH        = 4,
  parameter int PITCH_W     = 18,
  parameter int DUR_W       = 5,
  parameter int TICK_CYCLES = 6_250_000,
  parameter int GAP_CYCLES  = 0,
  parameter int PREEMPT     = 1,
  localparam int CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                    clk50,
  input  logic                    reset,
  input  logic [N_CH-1:0]         req_valid,
  output logic [N_CH-1:0]         req_ready,
  input  logic [N_CH*PITCH_W-1:0] req_pitch,
  input  logic [N_CH*DUR_W-1:0]   req_dur,
  output logic [PITCH_W-1:0]      pitch,
  output logic                    active,
  output logic [CH_W-1:0]         active_ch,
  output logic                    done,
  output logic [CH_W-1:0]         done_ch,
  output logic                    aborted
);

  localparam int TICK_W = $clog2(TICK_CYCLES + 1);
  localparam int GAP_W  = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYCLES - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

  state_t              state_q, state_d;
  logic [TICK_W-1:0]   tick_q, tick_d;
  logic [DUR_W-1:0]    unit_q, unit_d;
  logic [DUR_W-1:0]    dur_q, dur_d;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic [PITCH_W-1:0]  pitch_q, pitch_d;
  logic                active_q, active_d;
  logic [CH_W-1:0]     activeCh_q, activeCh_d;
  logic                done_q, done_d;
  logic [CH_W-1:0]     doneCh_q, doneCh_d;
  logic                aborted_q, aborted_d;

  logic [N_CH-1:0]     slotFull_q, slotFull_d;
  logic [PITCH_W-1:0]  slotPitch_q [N_CH];
  logic [PITCH_W-1:0]  slotPitch_d [N_CH];
  logic [DUR_W-1:0]    slotDur_q [N_CH];
  logic [DUR_W-1:0]    slotDur_d [N_CH];

  logic                anyPending;
  logic [CH_W-1:0]     pendCh;
  logic                higherPending;
  logic                toneEnd;
  logic                gapEnd;
  logic                launch;

  always_comb begin
    anyPending = |slotFull_q;
    pendCh     = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (slotFull_q[i]) pendCh = CH_W'(i);
    end
  end

  // The lowest pending index is below the playing channel only if some higher-priority slot is full.
  assign higherPending = anyPending && (pendCh < activeCh_q);
  assign toneEnd = (state_q == PLAY) && (tick_q == TICK_LAST) && (unit_q == dur_q - DUR_W'(1));
  assign gapEnd  = (state_q == GAP) && (gap_q == GAP_LAST);

  always_comb begin
    state_d    = state_q;
    tick_d     = tick_q;
    unit_d     = unit_q;
    dur_d      = dur_q;
    gap_d      = gap_q;
    pitch_d    = pitch_q;
    active_d   = active_q;
    activeCh_d = activeCh_q;
    doneCh_d   = doneCh_q;
    done_d     = 1'b0;
    aborted_d  = 1'b0;
    launch     = 1'b0;
    case (state_q)
      IDLE: launch = anyPending;
      PLAY: begin
        if (toneEnd) begin
          done_d   = 1'b1;
          doneCh_d = activeCh_q;
          pitch_d  = '0;
          active_d = 1'b0;
          if (GAP_CYCLES > 0) begin
            state_d = GAP;
            gap_d   = '0;
          end else begin
            state_d = IDLE;
            launch  = anyPending;
          end
        end else if ((PREEMPT != 0) && higherPending) begin
          done_d    = 1'b1;
          doneCh_d  = activeCh_q;
          aborted_d = 1'b1;
          launch    = 1'b1;
        end else if (tick_q == TICK_LAST) begin
          tick_d = '0;
          unit_d = unit_q + DUR_W'(1);
        end else begin
          tick_d = tick_q + TICK_W'(1);
        end
      end
      GAP: begin
        // The last gap cycle already behaves like IDLE so the silence lasts exactly GAP_CYCLES.
        if (gapEnd) begin
          state_d = IDLE;
          launch  = anyPending;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    if (launch) begin
      state_d    = PLAY;
      pitch_d    = slotPitch_q[pendCh];
      dur_d      = slotDur_q[pendCh];
      activeCh_d = pendCh;
      active_d   = 1'b1;
      tick_d     = '0;
      unit_d     = '0;
    end
  end

  // A zero-duration request is acknowledged but never occupies its slot.
  always_comb begin
    slotFull_d  = slotFull_q;
    slotPitch_d = slotPitch_q;
    slotDur_d   = slotDur_q;
    for (int i = 0; i < N_CH; i++) begin
      if (launch && (pendCh == CH_W'(i))) slotFull_d[i] = 1'b0;
      if (req_valid[i] && !slotFull_q[i] && (req_dur[i*DUR_W +: DUR_W] != '0)) begin
        slotFull_d[i]  = 1'b1;
        slotPitch_d[i] = req_pitch[i*PITCH_W +: PITCH_W];
        slotDur_d[i]   = req_dur[i*DUR_W +: DUR_W];
      end
    end
  end

  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      tick_q     <= '0;
      unit_q     <= '0;
      dur_q      <= '0;
      gap_q      <= '0;
      pitch_q    <= '0;
      active_q   <= 1'b0;
      activeCh_q <= '0;
      done_q     <= 1'b0;
      doneCh_q   <= '0;
      aborted_q  <= 1'b0;
      slotFull_q <= '0;
      for (int i = 0; i < N_CH; i++) begin
        slotPitch_q[i] <= '0;
        slotDur_q[i]   <= '0;
      end
    end else begin
      state_q     <= state_d;
      tick_q      <= tick_d;
      unit_q      <= unit_d;
      dur_q       <= dur_d;
      gap_q       <= gap_d;
      pitch_q     <= pitch_d;
      active_q    <= active_d;
      activeCh_q  <= activeCh_d;
      done_q      <= done_d;
      doneCh_q    <= doneCh_d;
      aborted_q   <= aborted_d;
      slotFull_q  <= slotFull_d;
      slotPitch_q <= slotPitch_d;
      slotDur_q   <= slotDur_d;
    end
  end

  assign req_ready = ~slotFull_q;
  assign pitch     = pitch_q;
  assign active    = active_q;
  assign active_ch = activeCh_q;
  assign done      = done_q;
  assign done_ch   = doneCh_q;
  assign aborted   = aborted_q;

endmodule

// File: tb/tb_tone_sequencer.sv
// Scoreboard bench for tone_sequencer: three instances (gapless pre-empting, gapless
// non-pre-empting, 3-cycle gap) with expected launch/done events queued per instance.
module tb_tone_sequencer;
  localparam int NCH  = 4;
  localparam int PW   = 18;
  localparam int DW   = 5;
  localparam int CW   = 2;
  localparam int NDUT = 3;

  typedef struct {
    int edgeNum;
    int ch;
    int val;
  } ev_t;

  logic clk50 = 1'b0;
  logic reset = 1'b1;
  int   edgeCnt = 0;

  logic [NCH-1:0]    reqValid [NDUT];
  logic [NCH-1:0]    reqReady [NDUT];
  logic [NCH*PW-1:0] reqPitch;
  logic [NCH*DW-1:0] reqDur;
  logic [PW-1:0]     pitchO [NDUT];
  logic              activeO [NDUT];
  logic [CW-1:0]     activeChO [NDUT];
  logic              doneO [NDUT];
  logic [CW-1:0]     doneChO [NDUT];
  logic              abortedO [NDUT];
  logic              prevActive [NDUT];

  ev_t doneQ [NDUT][$];
  ev_t launchQ [NDUT][$];

  int vectors = 0;
  int miscompares = 0;

  always #5 clk50 = ~clk50;

  always @(posedge clk50) edgeCnt <= edgeCnt + 1;

  tone_sequencer #(.N_CH(NCH), .PITCH_W(PW), .DUR_W(DW), .TICK_CYCLES(4), .GAP_CYCLES(0), .PREEMPT(1)) dut0 (
    .clk50(clk50), .reset(reset), .req_valid(reqValid[0]), .req_ready(reqReady[0]),
    .req_pitch(reqPitch), .req_dur(reqDur), .pitch(pitchO[0]), .active(activeO[0]),
    .active_ch(activeChO[0]), .done(doneO[0]), .done_ch(doneChO[0]), .aborted(abortedO[0]));

  tone_sequencer #(.N_CH(NCH), .PITCH_W(PW), .DUR_W(DW), .TICK_CYCLES(4), .GAP_CYCLES(0), .PREEMPT(0)) dut1 (
    .clk50(clk50), .reset(reset), .req_valid(reqValid[1]), .req_ready(reqReady[1]),
    .req_pitch(reqPitch), .req_dur(reqDur), .pitch(pitchO[1]), .active(activeO[1]),
    .active_ch(activeChO[1]), .done(doneO[1]), .done_ch(doneChO[1]), .aborted(abortedO[1]));

  tone_sequencer #(.N_CH(NCH), .PITCH_W(PW), .DUR_W(DW), .TICK_CYCLES(4), .GAP_CYCLES(3), .PREEMPT(1)) dut2 (
    .clk50(clk50), .reset(reset), .req_valid(reqValid[2]), .req_ready(reqReady[2]),
    .req_pitch(reqPitch), .req_dur(reqDur), .pitch(pitchO[2]), .active(activeO[2]),
    .active_ch(activeChO[2]), .done(doneO[2]), .done_ch(doneChO[2]), .aborted(abortedO[2]));

  task automatic checkOutput(input string tag, input int observed, input int expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic waitEdges(input int n);
    repeat (n) @(negedge clk50);
  endtask

  task automatic setReq(input int ch, input int p, input int dur);
    reqPitch[ch*PW +: PW] = PW'(p);
    reqDur[ch*DW +: DW]   = DW'(dur);
  endtask

  // Called at a falling edge; the request is captured on the next rising edge.
  task automatic applyStimulus(input int d, input logic [NCH-1:0] mask, output int acceptEdge);
    reqValid[d] = mask;
    acceptEdge  = edgeCnt + 1;
    @(negedge clk50);
    reqValid[d] = '0;
  endtask

  task automatic expectLaunch(input int d, input int e, input int ch, input int p);
    ev_t ev;
    ev.edgeNum = e;
    ev.ch      = ch;
    ev.val     = p;
    launchQ[d].push_back(ev);
  endtask

  task automatic expectDone(input int d, input int e, input int ch, input int ab);
    ev_t ev;
    ev.edgeNum = e;
    ev.ch      = ch;
    ev.val     = ab;
    doneQ[d].push_back(ev);
  endtask

  // A launch is a tone starting from silence or replacing the tone that just ended.
  task automatic monitor();
    ev_t ev;
    forever begin
      @(negedge clk50);
      for (int d = 0; d < NDUT; d++) begin
        if (doneO[d]) begin
          if (doneQ[d].size() == 0) begin
            checkOutput($sformatf("d%0d.unexpectedDone@%0d", d, edgeCnt), 1, 0);
          end else begin
            ev = doneQ[d].pop_front();
            checkOutput($sformatf("d%0d.doneEdge", d), edgeCnt, ev.edgeNum);
            checkOutput($sformatf("d%0d.doneCh", d), int'(doneChO[d]), ev.ch);
            checkOutput($sformatf("d%0d.aborted", d), int'(abortedO[d]), ev.val);
          end
          if (!activeO[d]) checkOutput($sformatf("d%0d.endPitch", d), int'(pitchO[d]), 0);
        end
        if (activeO[d] && (!prevActive[d] || doneO[d])) begin
          if (launchQ[d].size() == 0) begin
            checkOutput($sformatf("d%0d.unexpectedLaunch@%0d", d, edgeCnt), 1, 0);
          end else begin
            ev = launchQ[d].pop_front();
            checkOutput($sformatf("d%0d.launchEdge", d), edgeCnt, ev.edgeNum);
            checkOutput($sformatf("d%0d.launchCh", d), int'(activeChO[d]), ev.ch);
            checkOutput($sformatf("d%0d.launchPitch", d), int'(pitchO[d]), ev.val);
          end
        end
        prevActive[d] = activeO[d];
      end
    end
  endtask

  initial begin
    int e;
    int a;
    for (int d = 0; d < NDUT; d++) begin
      reqValid[d]   = '0;
      prevActive[d] = 1'b0;
    end
    reqPitch = '0;
    reqDur   = '0;
    fork
      monitor();
    join_none

    // Reset state.
    repeat (3) @(negedge clk50);
    for (int d = 0; d < NDUT; d++) begin
      checkOutput($sformatf("d%0d.rstReady", d), int'(reqReady[d]), 'hF);
      checkOutput($sformatf("d%0d.rstPitch", d), int'(pitchO[d]), 0);
    end
    checkOutput("rstActive", int'(activeO[0]), 0);
    checkOutput("rstActiveCh", int'(activeChO[0]), 0);
    checkOutput("rstDone", int'(doneO[0]), 0);
    checkOutput("rstDoneCh", int'(doneChO[0]), 0);
    checkOutput("rstAborted", int'(abortedO[0]), 0);
    reset = 1'b0;
    waitEdges(2);

    // Single ch2 tone of 3 ticks.
    setReq(2, 'hABC, 3);
    applyStimulus(0, 4'b0100, e);
    expectLaunch(0, e + 1, 2, 'hABC);
    expectDone(0, e + 13, 2, 0);
    checkOutput("s1.readyLow", int'(reqReady[0][2]), 0);
    waitEdges(1);
    checkOutput("s1.readyBack", int'(reqReady[0][2]), 1);
    checkOutput("s1.pitch", int'(pitchO[0]), 'hABC);
    waitEdges(14);

    // ch1 and ch3 together: ch1 first, ch3 back-to-back.
    setReq(1, 'h111, 1);
    setReq(3, 'h333, 1);
    applyStimulus(0, 4'b1010, e);
    expectLaunch(0, e + 1, 1, 'h111);
    expectDone(0, e + 5, 1, 0);
    expectLaunch(0, e + 5, 3, 'h333);
    expectDone(0, e + 9, 3, 0);
    waitEdges(12);

    // Pre-emption of ch3 by ch0.
    setReq(3, 'h3C3C, 5);
    applyStimulus(0, 4'b1000, e);
    expectLaunch(0, e + 1, 3, 'h3C3C);
    waitEdges(5);
    setReq(0, 'h0F0, 1);
    applyStimulus(0, 4'b0001, a);
    expectDone(0, a + 1, 3, 1);
    expectLaunch(0, a + 1, 0, 'h0F0);
    expectDone(0, a + 5, 0, 0);
    waitEdges(8);

    // Same sequence without pre-emption: ch3 runs its full 20 cycles.
    setReq(3, 'h3C3C, 5);
    applyStimulus(1, 4'b1000, e);
    expectLaunch(1, e + 1, 3, 'h3C3C);
    expectDone(1, e + 21, 3, 0);
    waitEdges(5);
    setReq(0, 'h0F0, 1);
    applyStimulus(1, 4'b0001, a);
    expectLaunch(1, e + 21, 0, 'h0F0);
    expectDone(1, e + 25, 0, 0);
    waitEdges(22);

    // Three-cycle gap between two ch0 tones.
    setReq(0, 'h555, 1);
    applyStimulus(2, 4'b0001, e);
    expectLaunch(2, e + 1, 0, 'h555);
    expectDone(2, e + 5, 0, 0);
    waitEdges(1);
    setReq(0, 'h556, 1);
    applyStimulus(2, 4'b0001, a);
    expectLaunch(2, e + 8, 0, 'h556);
    expectDone(2, e + 12, 0, 0);
    waitEdges(12);

    // Zero-duration request is swallowed.
    setReq(1, 'h999, 0);
    applyStimulus(0, 4'b0010, e);
    checkOutput("s5.zeroReady", int'(reqReady[0][1]), 1);
    checkOutput("s5.zeroPitch", int'(pitchO[0]), 0);
    checkOutput("s5.zeroActive", int'(activeO[0]), 0);
    waitEdges(4);

    // Refill ch1 while ch1 is playing.
    setReq(1, 'h121, 2);
    applyStimulus(0, 4'b0010, e);
    expectLaunch(0, e + 1, 1, 'h121);
    expectDone(0, e + 9, 1, 0);
    waitEdges(1);
    setReq(1, 'h122, 1);
    applyStimulus(0, 4'b0010, a);
    checkOutput("s5.refillHeld", int'(reqReady[0][1]), 0);
    checkOutput("s5.noRestart", int'(pitchO[0]), 'h121);
    expectLaunch(0, e + 9, 1, 'h122);
    expectDone(0, e + 13, 1, 0);
    waitEdges(14);

    // Reset mid-tone with every slot full.
    setReq(0, 'hA0, 4);
    setReq(1, 'hA1, 4);
    setReq(2, 'hA2, 4);
    setReq(3, 'hA3, 4);
    applyStimulus(0, 4'b1111, e);
    expectLaunch(0, e + 1, 0, 'hA0);
    waitEdges(1);
    setReq(0, 'hB0, 4);
    applyStimulus(0, 4'b0001, a);
    checkOutput("s6.allFull", int'(reqReady[0]), 0);
    checkOutput("s6.playing", int'(pitchO[0]), 'hA0);
    #2 reset = 1'b1;
    #1;
    checkOutput("s6.rstPitch", int'(pitchO[0]), 0);
    checkOutput("s6.rstActive", int'(activeO[0]), 0);
    checkOutput("s6.rstReady", int'(reqReady[0]), 'hF);
    checkOutput("s6.rstDone", int'(doneO[0]), 0);
    waitEdges(2);
    reset = 1'b0;
    waitEdges(10);
    checkOutput("s6.quietPitch", int'(pitchO[0]), 0);
    checkOutput("s6.quietActive", int'(activeO[0]), 0);
    checkOutput("s6.quietReady", int'(reqReady[0]), 'hF);

    for (int d = 0; d < NDUT; d++) begin
      checkOutput($sformatf("d%0d.pendingDone", d), doneQ[d].size(), 0);
      checkOutput($sformatf("d%0d.pendingLaunch", d), launchQ[d].size(), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/tone_sequencer.md
Name: tone_sequencer

Overview:
Multi-channel timed tone sequencer. It accepts tone requests (pitch plus duration in tick units) from N_CH gameplay event sources and buffers one request per channel. It arbitrates by fixed priority, optionally pre-empting a lower-priority tone. It drives a single registered pitch word to the audio codec path, with a configurable silent gap between tones.

Parameters:
N_CH, 4, number of request channels; channel 0 has the highest priority
PITCH_W, 18, pitch word width
DUR_W, 5, duration field width, in ticks
TICK_CYCLES, 6_250_000, clk50 cycles per duration tick (1/8 s at 50 MHz); must be >= 1
GAP_CYCLES, 0, silent cycles inserted after each tone ends normally; 0 means no gap
PREEMPT, 1, 1 lets a higher-priority pending request abort the playing tone; 0 disables

Ports:
clk50  in  1  system clock
reset  in  1  asynchronous, active-high reset
req_valid  in  N_CH  per-channel request strobe
req_ready  out  N_CH  per-channel buffer slot empty
req_pitch  in  N_CH*PITCH_W  channel i pitch at bits [i*PITCH_W +: PITCH_W]
req_dur  in  N_CH*DUR_W  channel i duration at bits [i*DUR_W +: DUR_W]
pitch  out  PITCH_W  current tone pitch; 0 = silence
active  out  1  tone playing
active_ch  out  max(1,$clog2(N_CH))  channel of the playing tone
done  out  1  one-cycle pulse when a tone ends
done_ch  out  max(1,$clog2(N_CH))  channel of the ended tone; valid with done
aborted  out  1  with done: tone was pre-empted

Behaviour:
- Reset (async, active-high): all slots empty; req_ready all 1; pitch=0; active=0; active_ch=0; done=0; done_ch=0; aborted=0; state IDLE; counters 0. Asserting reset mid-tone silences pitch immediately and drops all pending slots.
- Slot i: one-deep buffer. Accept on an edge where req_valid[i] && req_ready[i]; the edge captures pitch/dur. req_ready[i] = slot empty (registered). A request with dur=0 is accepted and discarded: slot stays empty, no tone, no done.
- Slot clears at the edge its request launches. req_ready[i] rises the following cycle. Channel i may refill while its own previous tone is still playing.
- States: IDLE, PLAY, GAP.
- IDLE: on any edge where some slot is non-empty, launch the lowest-index one. A request accepted at edge E launches at edge E+1 (slot visible from E). From E+1, pitch=slot pitch, active=1, active_ch=i, state=PLAY.
- PLAY: tick counter 0..TICK_CYCLES-1 and unit counter. The tone lasts exactly dur*TICK_CYCLES cycles. At the final edge: pitch=0, active=0, done=1 for one cycle, done_ch=i, aborted=0. Next state is GAP if GAP_CYCLES>0, else IDLE. With GAP_CYCLES=0 a pending slot launches at that same edge, so pitch goes directly to the new value and done still pulses.
- GAP: pitch=0 for exactly GAP_CYCLES cycles, then IDLE behaviour. Requests are accepted during GAP.
- Pre-emption (PREEMPT=1): in PLAY, if a slot j<active_ch is non-empty, at the next edge:
  - pitch=slot j pitch and counters restart;
  - done=1, done_ch=old channel, aborted=1;
  - no gap is inserted.
- Equal-or-lower priority never pre-empts. With PREEMPT=0 no pre-emption occurs.
- A request on the currently playing channel waits in its slot; it never restarts the playing tone.
- Counter widths: tick counter $clog2(TICK_CYCLES+1); unit counter DUR_W bits; gap counter $clog2(GAP_CYCLES+1). No multiplier; the tick/unit cascade has no overflow for any legal value.
- Simultaneous events:
  - Multiple channels pending: the lowest index wins; the others hold.
  - Normal end and higher-priority pending on the same edge: treated as a normal end (aborted=0).

Test Plan:
- TICK_CYCLES=4, GAP=0: ch2 dur=3 pitch=0x00ABC at edge 10 -> pitch=0x00ABC edges 11..22, pitch=0 at 23, done=1/done_ch=2/aborted=0 for one cycle, req_ready[2] low only during cycle 10->11.
- ch1 and ch3 both requested the same edge (dur=1 each) -> ch1 plays 4 cycles, then ch3 plays 4 cycles back-to-back; two done pulses with done_ch 1 then 3.
- PREEMPT=1: ch3 dur=5 playing, ch0 dur=1 arrives at cycle 6 of tone -> next edge pitch=ch0 pitch, done/aborted=1/done_ch=3; ch0 runs a full 4 cycles. Repeat with PREEMPT=0 -> ch3 completes 20 cycles, then ch0 plays.
- GAP_CYCLES=3: two back-to-back ch0 dur=1 requests -> tone 4 cycles, pitch=0 exactly 3 cycles, second tone 4 cycles.
- dur=0 request on ch1 -> req_ready[1] stays 1, pitch stays 0, no done; refill ch1 while ch1 playing -> queued, starts after current ends.
- Assert reset mid-PLAY with all slots full -> same cycle pitch=0, active=0, req_ready all 1; after release, no tone until a new request.
